// File: rtl/vid_timing_pkg.sv
// Shared definitions for the raster timing generator.
//  - vid_state_e : lock qualifier states
//  - VID_*       : 640x480@60 default timing constants
//  - vid_total() : total line/frame length from its four segments
package vid_timing_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } vid_state_e;

  localparam int unsigned VID_H_ACTIVE  = 640;
  localparam int unsigned VID_H_FP      = 16;
  localparam int unsigned VID_H_SYNC    = 96;
  localparam int unsigned VID_H_BP      = 48;
  localparam int unsigned VID_V_ACTIVE  = 480;
  localparam int unsigned VID_V_FP      = 10;
  localparam int unsigned VID_V_SYNC    = 2;
  localparam int unsigned VID_V_BP      = 33;
  localparam int unsigned VID_LOCK_WAIT = 1024;
  localparam int unsigned VID_CNT_W     = 12;

  function automatic int unsigned vid_total(input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vid_lock_qual.sv
// PLL lock qualifier: waits for pll_locked, requires it to stay high for
// LOCK_WAIT consecutive clocks, then reports RUN. Any low sample of
// pll_locked returns to WAIT_LOCK on the next edge.
// Ports:
//  clk_vid    in  pixel clock
//  rst_n      in  synchronous reset, active-low
//  pll_locked in  lock flag (already synchronised)
//  run_ok     out registered, 1 while in RUN
//  run_next   out combinational, 1 when the next state is RUN
module vid_lock_qual
  import vid_timing_pkg::*;
#(
  parameter int unsigned LOCK_WAIT = VID_LOCK_WAIT
) (
  input  logic clk_vid,
  input  logic rst_n,
  input  logic pll_locked,
  output logic run_ok,
  output logic run_next
);

  localparam int unsigned LW_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

  vid_state_e      state_q, state_d;
  logic [LW_W-1:0] cnt_q, cnt_d;
  logic            run_ok_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!pll_locked) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
        SETTLE: begin
          if (cnt_q == LW_W'(LOCK_WAIT - 1)) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN:     state_d = RUN;
        default: state_d = WAIT_LOCK;
      endcase
    end
  end

  assign run_next = (state_d == RUN);

  always_ff @(posedge clk_vid) begin
    if (!rst_n) begin
      state_q  <= WAIT_LOCK;
      cnt_q    <= '0;
      run_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      run_ok_q <= run_next;
    end
  end

  assign run_ok = run_ok_q;

endmodule

// File: rtl/vid_timing_gen.sv
// Raster timing generator (default 640x480@60). Holds video idle until the
// PLL lock has been stable for LOCK_WAIT clocks, then produces registered
// sync, blank, DE, pixel coordinates and a start-of-frame pulse.
// Optional macro VID_CSYNC_EN adds the composite sync output csync.
// Ports:
//  clk_vid    in  pixel clock
//  rst_n      in  synchronous reset, active-low
//  pll_locked in  PLL lock flag, synchronised to clk_vid
//  ce_pix     in  pixel enable; counters advance only when 1
//  hsync      out horizontal sync, asserted level HS_POL
//  vsync      out vertical sync, asserted level VS_POL
//  hblank     out 1 outside the active columns
//  vblank     out 1 outside the active lines
//  de         out display enable
//  x, y       out current column / line
//  sof        out one-clock start-of-frame pulse
//  running    out 1 while the lock qualifier is in RUN
//  csync      out composite sync (VID_CSYNC_EN only), asserted level HS_POL
module vid_timing_gen
  import vid_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = VID_H_ACTIVE,
  parameter int unsigned H_FP      = VID_H_FP,
  parameter int unsigned H_SYNC    = VID_H_SYNC,
  parameter int unsigned H_BP      = VID_H_BP,
  parameter int unsigned V_ACTIVE  = VID_V_ACTIVE,
  parameter int unsigned V_FP      = VID_V_FP,
  parameter int unsigned V_SYNC    = VID_V_SYNC,
  parameter int unsigned V_BP      = VID_V_BP,
  parameter logic        HS_POL    = 1'b0,
  parameter logic        VS_POL    = 1'b0,
  parameter int unsigned LOCK_WAIT = VID_LOCK_WAIT,
  parameter int unsigned CNT_W     = VID_CNT_W
) (
  input  logic             clk_vid,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             ce_pix,
  output logic             hsync,
  output logic             vsync,
  output logic             hblank,
  output logic             vblank,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             sof,
  output logic             running
`ifdef VID_CSYNC_EN
  ,
  output logic             csync
`endif
);

  localparam int unsigned H_TOTAL = vid_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = vid_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL >= (64'd1 << CNT_W)) begin : g_chk_h
    $error("vid_timing_gen: H_TOTAL does not fit in CNT_W");
  end
  if (V_TOTAL >= (64'd1 << CNT_W)) begin : g_chk_v
    $error("vid_timing_gen: V_TOTAL does not fit in CNT_W");
  end
  if (LOCK_WAIT < 1) begin : g_chk_lw
    $error("vid_timing_gen: LOCK_WAIT must be >= 1");
  end

  logic run_q, run_next;

  vid_lock_qual #(
    .LOCK_WAIT (LOCK_WAIT)
  ) u_lock_qual (
    .clk_vid    (clk_vid),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .run_ok     (run_q),
    .run_next   (run_next)
  );

  logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic             hblank_q, hblank_d, vblank_q, vblank_d;
  logic             de_q, de_d, sof_q, sof_d;
  logic             csync_q, csync_d;
  logic             hs_act, vs_act, hbl, vbl;

  always_comb begin
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    x_d      = x_q;
    y_d      = y_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    hblank_d = hblank_q;
    vblank_d = vblank_q;
    de_d     = de_q;
    csync_d  = csync_q;
    sof_d    = 1'b0;

    hs_act = (hcnt_q >= CNT_W'(H_ACTIVE + H_FP)) &&
             (hcnt_q <  CNT_W'(H_ACTIVE + H_FP + H_SYNC));
    vs_act = (vcnt_q >= CNT_W'(V_ACTIVE + V_FP)) &&
             (vcnt_q <  CNT_W'(V_ACTIVE + V_FP + V_SYNC));
    hbl    = (hcnt_q >= CNT_W'(H_ACTIVE));
    vbl    = (vcnt_q >= CNT_W'(V_ACTIVE));

    if (!run_next) begin
      // Lock lost or not yet qualified: everything idles at reset values.
      hcnt_d   = '0;
      vcnt_d   = '0;
      x_d      = '0;
      y_d      = '0;
      hsync_d  = ~HS_POL;
      vsync_d  = ~VS_POL;
      hblank_d = 1'b1;
      vblank_d = 1'b1;
      de_d     = 1'b0;
      csync_d  = ~HS_POL;
    end else if (!run_q || ce_pix) begin
      // On the edge entering RUN the counters are still zero, so pixel (0,0)
      // is published without advancing; the first ce_pix in RUN then
      // re-presents (0,0) together with sof and starts counting.
      x_d      = hcnt_q;
      y_d      = vcnt_q;
      hsync_d  = hs_act ? HS_POL : ~HS_POL;
      vsync_d  = vs_act ? VS_POL : ~VS_POL;
      hblank_d = hbl;
      vblank_d = vbl;
      de_d     = ~hbl & ~vbl;
      csync_d  = (hs_act ^ vs_act) ? HS_POL : ~HS_POL;
      if (run_q) begin
        sof_d = (hcnt_q == '0) && (vcnt_q == '0);
        if (hcnt_q == CNT_W'(H_TOTAL - 1)) begin
          hcnt_d = '0;
          vcnt_d = (vcnt_q == CNT_W'(V_TOTAL - 1)) ? '0 : vcnt_q + 1'b1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_vid) begin
    if (!rst_n) begin
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      hblank_q <= 1'b1;
      vblank_q <= 1'b1;
      de_q     <= 1'b0;
      sof_q    <= 1'b0;
      csync_q  <= ~HS_POL;
    end else begin
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
      de_q     <= de_d;
      sof_q    <= sof_d;
      csync_q  <= csync_d;
    end
  end

  assign hsync   = hsync_q;
  assign vsync   = vsync_q;
  assign hblank  = hblank_q;
  assign vblank  = vblank_q;
  assign de      = de_q;
  assign x       = x_q;
  assign y       = y_q;
  assign sof     = sof_q;
  assign running = run_q;

`ifdef VID_CSYNC_EN
  assign csync = csync_q;
`else
  logic unused_csync;
  assign unused_csync = csync_q;
`endif

endmodule
